// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures ALU or load data and drives the
// register-file write port. It also handles variable-latency load waits.
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 24,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      writeback_enable,
  input  logic                      mem_read_enable,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_rvalid,
  input  logic                      flush,
  output logic                      stall_out,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      pend_valid,
  output logic [REG_ADDR_WIDTH-1:0] pend_addr,
  output logic                      mem_timeout_err
);

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                    state, state_n;
  logic [7:0]                cnt, cnt_n;
  logic                      wait_we, wait_we_n;
  logic [REG_ADDR_WIDTH-1:0] wait_addr, wait_addr_n;
  logic                      we_n;
  logic [REG_ADDR_WIDTH-1:0] waddr_n;
  logic [DATA_WIDTH-1:0]     wdata_n;
  logic                      stall_n;
  logic                      pend_n;
  logic                      err_n;
  logic                      rd_nz;
  logic                      wait_nz;

  assign rd_nz     = (rd_addr != '0);
  assign wait_nz   = (wait_addr != '0);
  assign pend_addr = wait_addr;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    wait_we_n   = wait_we;
    wait_addr_n = wait_addr;
    we_n        = 1'b0;
    waddr_n     = rf_waddr;
    wdata_n     = rf_wdata;
    stall_n     = 1'b0;
    pend_n      = 1'b0;
    err_n       = mem_timeout_err;
    unique case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          if (!mem_read_enable) begin
            we_n    = writeback_enable && rd_nz;
            waddr_n = rd_addr;
            wdata_n = alu_result;
          end else if (mem_rvalid) begin
            we_n    = writeback_enable && rd_nz;
            waddr_n = rd_addr;
            wdata_n = mem_rdata;
          end else begin
            state_n     = WAIT_MEM;
            cnt_n       = '0;
            wait_we_n   = writeback_enable;
            wait_addr_n = rd_addr;
            stall_n     = 1'b1;
            pend_n      = writeback_enable;
          end
        end
      end
      WAIT_MEM: begin
        // flush wins over a same-cycle data return
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (mem_rvalid) begin
          state_n = IDLE;
          cnt_n   = '0;
          we_n    = wait_we && wait_nz;
          waddr_n = wait_addr;
          wdata_n = mem_rdata;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n   = cnt + 8'd1;
          stall_n = 1'b1;
          pend_n  = wait_we;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      wait_we         <= 1'b0;
      wait_addr       <= '0;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      stall_out       <= 1'b0;
      pend_valid      <= 1'b0;
      mem_timeout_err <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      wait_we         <= wait_we_n;
      wait_addr       <= wait_addr_n;
      rf_we           <= we_n;
      rf_waddr        <= waddr_n;
      rf_wdata        <= wdata_n;
      stall_out       <= stall_n;
      pend_valid      <= pend_n;
      mem_timeout_err <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: expected register writes are queued as driven
// and matched against rf_we pulses; control outputs are checked directly.
module tb_mem_wb_stage;

  localparam int DW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          writeback_enable;
  logic          mem_read_enable;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          flush;
  logic          stall_out;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic          mem_timeout_err;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  mem_wb_stage #(
    .DATA_WIDTH(DW),
    .REG_ADDR_WIDTH(AW),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .writeback_enable(writeback_enable),
    .mem_read_enable(mem_read_enable),
    .rd_addr(rd_addr),
    .alu_result(alu_result),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .flush(flush),
    .stall_out(stall_out),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pend_valid(pend_valid),
    .pend_addr(pend_addr),
    .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

  task automatic alu_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid         = 1'b1;
    writeback_enable = 1'b1;
    mem_read_enable  = 1'b0;
    rd_addr          = a;
    alu_result       = d;
  endtask

  task automatic load_op(input logic [AW-1:0] a);
    in_valid         = 1'b1;
    writeback_enable = 1'b1;
    mem_read_enable  = 1'b1;
    rd_addr          = a;
  endtask

  task automatic idle_in();
    in_valid        = 1'b0;
    mem_read_enable = 1'b0;
    mem_rvalid      = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 32'(rf_we), 32'd0);
    check({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
    check({tag, "_stall"}, 32'(stall_out), 32'd0);
    check({tag, "_pend"}, 32'(pend_valid), 32'd0);
    check({tag, "_paddr"}, 32'(pend_addr), 32'd0);
    check({tag, "_err"}, 32'(mem_timeout_err), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(rf_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("sb_waddr", 32'(rf_waddr), 32'(w.a));
        check("sb_wdata", 32'(rf_wdata), 32'(w.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    writeback_enable = 1'b0;
    rd_addr          = '0;
    alu_result       = '0;
    mem_rdata        = '0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_zero("reset");

    // back-to-back ALU writes
    alu_op(4'd3, 24'h000001);
    push(4'd3, 24'h000001);
    tick();
    check("alu1_we", 32'(rf_we), 32'd1);
    alu_op(4'd3, 24'h000002);
    push(4'd3, 24'h000002);
    tick();
    check("alu2_we", 32'(rf_we), 32'd1);
    idle_in();
    tick();
    check("alu_pulse", 32'(rf_we), 32'd0);

    // load hit in the same cycle
    load_op(4'd5);
    mem_rvalid = 1'b1;
    mem_rdata  = 24'hABCDEF;
    push(4'd5, 24'hABCDEF);
    tick();
    idle_in();
    check("hit_stall", 32'(stall_out), 32'd0);
    check("hit_we", 32'(rf_we), 32'd1);
    tick();

    // load returning four cycles after accept
    load_op(4'd7);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      check("dly_stall", 32'(stall_out), 32'd1);
      check("dly_pend", 32'(pend_valid), 32'd1);
      check("dly_paddr", 32'(pend_addr), 32'd7);
      check("dly_we", 32'(rf_we), 32'd0);
      if (i == 3) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 24'h123456;
        push(4'd7, 24'h123456);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    check("dly_stall_fall", 32'(stall_out), 32'd0);
    check("dly_pend_fall", 32'(pend_valid), 32'd0);
    check("dly_we_rise", 32'(rf_we), 32'd1);
    alu_op(4'd9, 24'h00AA55);
    push(4'd9, 24'h00AA55);
    tick();
    check("b2b_we", 32'(rf_we), 32'd1);
    idle_in();
    tick();

    // timeout after 15 wait cycles
    load_op(4'd4);
    tick();
    idle_in();
    for (int i = 0; i < 15; i++) begin
      check("to_stall", 32'(stall_out), 32'd1);
      check("to_err_early", 32'(mem_timeout_err), 32'd0);
      tick();
    end
    check("to_err", 32'(mem_timeout_err), 32'd1);
    check("to_stall_fall", 32'(stall_out), 32'd0);
    check("to_we", 32'(rf_we), 32'd0);
    alu_op(4'd2, 24'h777777);
    push(4'd2, 24'h777777);
    tick();
    idle_in();
    check("to_after_we", 32'(rf_we), 32'd1);
    check("to_err_sticky", 32'(mem_timeout_err), 32'd1);
    tick();

    // flush beats mem_rvalid while waiting
    load_op(4'd6);
    tick();
    idle_in();
    tick();
    flush      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 24'hFFFFFF;
    tick();
    idle_in();
    check("fl_we", 32'(rf_we), 32'd0);
    check("fl_stall", 32'(stall_out), 32'd0);
    check("fl_pend", 32'(pend_valid), 32'd0);
    alu_op(4'd1, 24'h0000C3);
    push(4'd1, 24'h0000C3);
    tick();
    idle_in();
    check("fl_idle_we", 32'(rf_we), 32'd1);
    tick();

    // writes to x0 are suppressed but address/data still move
    alu_op(4'd0, 24'h0F0F0F);
    tick();
    idle_in();
    check("x0_we", 32'(rf_we), 32'd0);
    check("x0_waddr", 32'(rf_waddr), 32'd0);
    check("x0_wdata", 32'(rf_wdata), 32'h0F0F0F);
    tick();

    // reset while waiting
    load_op(4'd8);
    tick();
    idle_in();
    tick();
    check("rw_stall", 32'(stall_out), 32'd1);
    rst = 1'b1;
    tick();
    check_zero("rst_wait");
    rst = 1'b0;
    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
